// File: rtl/restoring_divider.sv
// Sequential 8-bit restoring divider: one shift-subtract-restore step per clock, results after 8
// iterations. Define RESTORING_DIVIDER_SIGNED_EN for two's-complement operands and results.
module restoring_divider (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic [7:0] Dividend,
  input  logic [7:0] Divisor,
  output logic [7:0] Quotient,
  output logic [7:0] Remainder,
  output logic       Busy,
  output logic       Done,
  output logic       DivByZero
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e     state;
  logic [7:0] r;
  logic [7:0] q;
  logic [7:0] d;
  logic [2:0] cnt;

  logic [8:0] shifted;
  logic [8:0] t;
  logic [7:0] r_next;
  logic [7:0] q_next;
  logic [7:0] q_res;
  logic [7:0] r_res;
  logic [7:0] dvd_load;
  logic [7:0] dvs_load;

`ifdef RESTORING_DIVIDER_SIGNED_EN
  logic dvd_neg;
  logic dvs_neg;
`endif

  // The partial remainder is always below the divisor, so its ninth bit is always zero and only
  // the shifted value needs the full 9-bit subtractor.
  always_comb begin
    shifted = {r, q[7]};
    t       = shifted - {1'b0, d};
    if (!t[8]) begin
      r_next = t[7:0];
      q_next = {q[6:0], 1'b1};
    end else begin
      r_next = shifted[7:0];
      q_next = {q[6:0], 1'b0};
    end
`ifdef RESTORING_DIVIDER_SIGNED_EN
    // Negating 0x80 yields 0x80, which the unsigned datapath reads as magnitude 128.
    dvd_load = Dividend[7] ? (8'd0 - Dividend) : Dividend;
    dvs_load = Divisor[7] ? (8'd0 - Divisor) : Divisor;
    q_res    = (dvd_neg ^ dvs_neg) ? (8'd0 - q_next) : q_next;
    r_res    = dvd_neg ? (8'd0 - r_next) : r_next;
`else
    dvd_load = Dividend;
    dvs_load = Divisor;
    q_res    = q_next;
    r_res    = r_next;
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= StIdle;
      r         <= '0;
      q         <= '0;
      d         <= '0;
      cnt       <= '0;
      Quotient  <= '0;
      Remainder <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
      dvd_neg   <= 1'b0;
      dvs_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        StIdle: begin
          if (Run) begin
            q   <= dvd_load;
            d   <= dvs_load;
            r   <= '0;
            cnt <= '0;
`ifdef RESTORING_DIVIDER_SIGNED_EN
            dvd_neg <= Dividend[7];
            dvs_neg <= Divisor[7];
`endif
            if (Divisor == 8'd0) begin
              state     <= StDone;
              Done      <= 1'b1;
              Quotient  <= 8'hFF;
              Remainder <= Dividend;
              DivByZero <= 1'b1;
            end else begin
              state     <= StCalc;
              Busy      <= 1'b1;
              DivByZero <= 1'b0;
            end
          end
        end
        StCalc: begin
          r   <= r_next;
          q   <= q_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            Quotient  <= q_res;
            Remainder <= r_res;
            Busy      <= 1'b0;
            Done      <= 1'b1;
            state     <= StDone;
          end
        end
        StDone: begin
          if (!Run) begin
            state <= StIdle;
            Done  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider: directed vectors, divide by zero, Run hold, reset
// mid-calculation and randomized operands against an arithmetic reference model.
module tb_restoring_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int asserts = 0;
  int fails   = 0;

  restoring_divider dut (
    .Clk       (clk),
    .Reset     (rst),
    .Run       (run),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .Quotient  (quotient),
    .Remainder (remainder),
    .Busy      (busy),
    .Done      (done),
    .DivByZero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference model: returns {div_by_zero, quotient, remainder} from plain integer division.
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    int qi;
    int ri;
    if (b == 8'd0) return {1'b1, 8'hFF, a};
`ifdef RESTORING_DIVIDER_SIGNED_EN
    qi = int'($signed(a)) / int'($signed(b));
    ri = int'($signed(a)) % int'($signed(b));
`else
    qi = int'(a) / int'(b);
    ri = int'(a) % int'(b);
`endif
    return {1'b0, qi[7:0], ri[7:0]};
  endfunction

  task automatic start_div(input logic [7:0] a, input logic [7:0] b, input bit hold);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    run      = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) run = 1'b0;
    dividend = 8'($urandom);
    divisor  = 8'($urandom);
  endtask

  task automatic wait_done(output int busy_cnt, output bit overlap, output bit timed_out);
    busy_cnt  = 0;
    overlap   = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy && done) overlap = 1'b1;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    run = 1'b0;
    dividend = 8'h00;
    divisor = 8'h00;
    repeat (2) @(negedge clk);
    asserts++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++;
      $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b, want all zero",
               quotient, remainder, busy, done, div_by_zero);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    asserts++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [31:0] vecs[$];
    int bc;
    bit ov;
    bit to;
`ifdef RESTORING_DIVIDER_SIGNED_EN
    vecs = '{32'hC807_F800, 32'h07C8_0007, 32'hFF01_FF00, 32'h6409_0B01,
             32'h9C07_F2FE, 32'h80FF_8000, 32'h64F7_F501};
`else
    vecs = '{32'hC807_1C04, 32'h07C8_0007, 32'hFF01_FF00, 32'h6409_0B01};
`endif
    foreach (vecs[k]) begin
      logic [31:0] v;
      v = vecs[k];
      start_div(v[31:24], v[23:16], 1'b0);
      wait_done(bc, ov, to);
      asserts++;
      if (to || bc != 8 || ov) begin
        fails++;
        $display("FAIL directed_timing %h/%h: got busy_cycles=%0d timeout=%b overlap=%b, want 8 0 0",
                 v[31:24], v[23:16], bc, to, ov);
      end
      asserts++;
      if ({quotient, remainder, div_by_zero} !== {v[15:8], v[7:0], 1'b0}) begin
        fails++;
        $display("FAIL directed_result %h/%h: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=0",
                 v[31:24], v[23:16], quotient, remainder, div_by_zero, v[15:8], v[7:0]);
      end
    end
  endtask

  task automatic test_div_zero();
    int bc;
    bit ov;
    bit to;
    start_div(8'h05, 8'h00, 1'b0);
    wait_done(bc, ov, to);
    asserts++;
    if (to || bc != 0 || ov) begin
      fails++;
      $display("FAIL dbz_timing: got busy_cycles=%0d timeout=%b overlap=%b, want 0 0 0", bc, to, ov);
    end
    asserts++;
    if ({quotient, remainder, div_by_zero} !== {8'hFF, 8'h05, 1'b1}) begin
      fails++;
      $display("FAIL dbz_result: got q=%h r=%h dbz=%b, want q=ff r=05 dbz=1",
               quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    asserts++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL dbz_done_pulse: got done=%b one cycle later, want 0", done);
    end
    start_div(8'h09, 8'h03, 1'b0);
    wait_done(bc, ov, to);
    asserts++;
    if (to || {quotient, remainder, div_by_zero} !== {8'h03, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL dbz_clear: got q=%h r=%h dbz=%b timeout=%b, want q=03 r=00 dbz=0",
               quotient, remainder, div_by_zero, to);
    end
  endtask

  task automatic test_run_hold();
    int bc;
    bit ov;
    bit to;
    logic [16:0] exp;
    exp = model(8'hB4, 8'h0D);
    start_div(8'hB4, 8'h0D, 1'b1);
    wait_done(bc, ov, to);
    asserts++;
    if (to || bc != 8) begin
      fails++;
      $display("FAIL hold_timing: got busy_cycles=%0d timeout=%b, want 8 0", bc, to);
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      asserts++;
      if ({done, busy, quotient, remainder} !== {1'b1, 1'b0, exp[15:0]}) begin
        fails++;
        $display("FAIL hold_cycle%0d: got done=%b busy=%b q=%h r=%h, want 1 0 q=%h r=%h",
                 k, done, busy, quotient, remainder, exp[15:8], exp[7:0]);
      end
    end
    run = 1'b0;
    @(posedge clk);
    #1;
    asserts++;
    if ({done, busy} !== 2'b00) begin
      fails++;
      $display("FAIL hold_release: got done=%b busy=%b, want 0 0", done, busy);
    end
    exp = model(8'h3C, 8'h05);
    start_div(8'h3C, 8'h05, 1'b0);
    wait_done(bc, ov, to);
    asserts++;
    if (to || {div_by_zero, quotient, remainder} !== exp) begin
      fails++;
      $display("FAIL hold_restart: got q=%h r=%h timeout=%b, want q=%h r=%h",
               quotient, remainder, to, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    int bc;
    bit ov;
    bit to;
    int seen;
    logic [16:0] exp;
    start_div(8'hC8, 8'h07, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen < 4; i++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    rst = 1'b1;
    #1;
    asserts++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 19'd0) begin
      fails++;
      $display("FAIL reset_mid: got q=%h r=%h busy=%b done=%b dbz=%b (busy seen %0d), want zero",
               quotient, remainder, busy, done, div_by_zero, seen);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    asserts++;
    if ({busy, done} !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    exp = model(8'h64, 8'h09);
    start_div(8'h64, 8'h09, 1'b0);
    wait_done(bc, ov, to);
    asserts++;
    if (to || bc != 8 || {div_by_zero, quotient, remainder} !== exp) begin
      fails++;
      $display("FAIL reset_mid_after: got q=%h r=%h busy_cycles=%0d timeout=%b, want q=%h r=%h 8",
               quotient, remainder, bc, to, exp[15:8], exp[7:0]);
    end
  endtask

  task automatic test_random();
    int bc;
    bit ov;
    bit to;
    logic [7:0] a;
    logic [7:0] b;
    logic [16:0] exp;
    for (int n = 0; n < 40; n++) begin
      a = 8'($urandom);
      b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      exp = model(a, b);
      start_div(a, b, 1'b0);
      wait_done(bc, ov, to);
      asserts++;
      if (to || ov || bc != ((b == 8'd0) ? 0 : 8) ||
          {div_by_zero, quotient, remainder} !== exp) begin
        fails++;
        $display("FAIL random %h/%h: got q=%h r=%h dbz=%b busy_cycles=%0d to=%b ov=%b, want q=%h r=%h dbz=%b",
                 a, b, quotient, remainder, div_by_zero, bc, to, ov, exp[15:8], exp[7:0], exp[16]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_div_zero();
    test_run_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential 8-bit restoring divider for the lab 5 arithmetic datapath, the inverse companion to the shift-add multiplier. It takes an 8-bit dividend and divisor on a Run request and iterates one shift-subtract-restore step per clock using a 9-bit internal subtractor. It returns an 8-bit quotient and an 8-bit remainder after a fixed latency. It uses the same Run-driven control style as the multiplier so both can share switch/button front-end logic.

## Interface
- No parameters; operand width is fixed at 8 bits.
- Clk — in — 1 — system clock; all state changes on rising edge.
- Reset — in — 1 — asynchronous, active-high; forces IDLE and clears all registers.
- Run — in — 1 — level-sensitive start request.
- Dividend — in — 8 — dividend; sampled only on the start edge.
- Divisor — in — 8 — divisor; sampled only on the start edge.
- Quotient — out — 8 — registered result; reset 0x00.
- Remainder — out — 8 — registered result; reset 0x00.
- Busy — out — 1 — high while in CALC; reset 0.
- Done — out — 1 — high while in DONE; reset 0.
- DivByZero — out — 1 — set with the result when Divisor was 0; reset 0.

## Operation
- Registers:
  - R[8:0] holds the partial remainder.
  - Q[7:0] shifts the dividend in and collects the quotient.
  - D[7:0] holds the divisor.
  - cnt[2:0] counts iterations.
- The three states are IDLE, CALC and DONE.
- IDLE:
  - If Run=1, load Q←Dividend, D←Divisor, R←0 and cnt←0.
  - If Divisor=0, go to DONE. Otherwise go to CALC.
- CALC iteration (one per cycle):
  - Compute T = {R[7:0],Q[7]} − {1'b0,D} in 9 bits.
  - If T[8]=0: R←T and Q←{Q[6:0],1}.
  - Otherwise: R←{R[7:0],Q[7]} (restore) and Q←{Q[6:0],0}.
  - cnt increments each iteration.
  - On the iteration where cnt=7, load Quotient←final Q and Remainder←final R[7:0], then go to DONE.
- Quotient and Remainder hold their previous values throughout CALC. They change only on the edge that enters DONE.
- Divide by zero: Quotient←0xFF, Remainder←Dividend, DivByZero←1.
- DivByZero clears on the next start edge of a non-zero division.
- DONE:
  - Stay in DONE while Run=1.
  - When Run=0, go to IDLE.
  - Each division therefore needs Run released before the next one can start.
- Run changes during CALC are ignored. The computation always completes.
- Operand inputs may change freely after the start edge.

## Timing
- Start edge E0 is the edge on which IDLE samples Run=1. Busy rises after E0.
- Edges E1..E8 perform iterations 0..7. At E8 the results load, Busy falls and Done rises.
- Latency is 8 cycles from Busy rising to Done rising.
- Divide by zero skips CALC: E0 goes directly to DONE, so Done and the results appear after E0.
- If Run is already low when DONE is entered, Done is high for exactly one cycle.
- Reset asserted at any time, including mid-CALC, immediately clears:
  - the state (to IDLE),
  - R, Q, D and cnt,
  - all outputs, to 0.
- After Reset deasserts, a start needs Run high at a subsequent edge.
- Busy and Done are never high at the same time.

## Configuration
- Macro: RESTORING_DIVIDER_SIGNED_EN.
- Not defined: operands and results are unsigned.
- Defined: operands and results are two's complement.
  - At E0, load the magnitudes |Dividend| and |Divisor| and latch both sign bits.
  - When loading results, negate the Quotient if the two signs differ.
  - Negate the Remainder if the Dividend was negative, so the remainder takes the dividend's sign.
  - −128/−1 wraps: Quotient=0x80, Remainder=0x00.
  - The magnitude of −128 is computed as 9-bit 128, so the datapath must not truncate it.
  - Divide by zero behaves identically to the unsigned case.
- Latency is the same with and without the macro.

## Test plan
- Unsigned 200/7 (0xC8/0x07), Run held one cycle → Done after 8 Busy cycles, Quotient=0x1C, Remainder=0x04, DivByZero=0.
- Unsigned 7/200 → Quotient=0x00, Remainder=0x07.
- Unsigned 255/1 → Quotient=0xFF, Remainder=0x00.
- 5/0 → Done one cycle after the start edge, Busy never high, Quotient=0xFF, Remainder=0x05, DivByZero=1. A following 9/3 → Quotient=0x03, Remainder=0x00, DivByZero=0.
- Run held high through DONE for 5 cycles → Done stays high and no restart occurs. Dropping Run → IDLE next edge. Reasserting Run → a new division with new operands.
- Reset pulsed during the 4th CALC cycle → all outputs 0 and state IDLE. A subsequent 100/9 → Quotient=0x0B, Remainder=0x01.
- With RESTORING_DIVIDER_SIGNED_EN: the following must hold.
  - −100/7 → Quotient=0xF2 (−14), Remainder=0xFE (−2).
  - −128/−1 → Quotient=0x80, Remainder=0x00.
  - 100/−9 → Quotient=0xF5, Remainder=0x01.
